// File: rtl/pwr_gate_seq.sv
// Power-gating sequencer: per-domain save/isolate/switch-off and switch-on/restore FSMs
// with one-at-a-time ramp-up arbitration. Optional wake counters under PWR_WAKE_CNT_EN.
module pwr_gate_seq #(
    parameter int N_DOM    = 2,
    parameter int ISO_DLY  = 2,
    parameter int RAMP_DLY = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DOM-1:0] pwr_req,
    output logic [N_DOM-1:0] pwr_sw_en,
    output logic [N_DOM-1:0] iso_en,
    output logic [N_DOM-1:0] ret_save,
    output logic [N_DOM-1:0] ret_restore,
    output logic [N_DOM-1:0] dom_rst,
    output logic [N_DOM-1:0] pwr_ack,
    output logic             busy
`ifdef PWR_WAKE_CNT_EN
    ,
    output logic [N_DOM*CNT_W-1:0] wake_cnt
`endif
);

    localparam int MAX_DLY = (ISO_DLY > RAMP_DLY) ? ISO_DLY : RAMP_DLY;
    localparam int DW      = $clog2(MAX_DLY + 1);
    localparam logic [DW-1:0] ISO_LAST  = DW'(ISO_DLY - 1);
    localparam logic [DW-1:0] RAMP_LAST = DW'(RAMP_DLY - 1);

    if (N_DOM < 1 || N_DOM > 16 || ISO_DLY < 1 || RAMP_DLY < 1 || CNT_W < 1) begin : g_param_check
        $error("pwr_gate_seq: illegal parameter value");
    end

    typedef enum logic [2:0] {
        ST_ON      = 3'd0,
        ST_SAVE    = 3'd1,
        ST_ISO     = 3'd2,
        ST_OFF     = 3'd3,
        ST_UP      = 3'd4,
        ST_RESTORE = 3'd5
    } state_e;

    state_e        state_q [N_DOM];
    state_e        state_d [N_DOM];
    logic [DW-1:0] dly_q   [N_DOM];
    logic [DW-1:0] dly_d   [N_DOM];
    logic          any_up;
    logic          taken;
    logic [N_DOM-1:0] grant;

    // Inrush limit: nobody new ramps while any domain is still in UP; lowest index wins.
    always_comb begin
        any_up = 1'b0;
        taken  = 1'b0;
        grant  = '0;
        for (int i = 0; i < N_DOM; i++) begin
            if (state_q[i] == ST_UP) any_up = 1'b1;
        end
        for (int i = 0; i < N_DOM; i++) begin
            if (!any_up && !taken && state_q[i] == ST_OFF && pwr_req[i]) begin
                grant[i] = 1'b1;
                taken    = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_DOM; i++) begin
            state_d[i] = state_q[i];
            dly_d[i]   = dly_q[i];
            case (state_q[i])
                ST_ON: begin
                    if (!pwr_req[i]) state_d[i] = ST_SAVE;
                end
                ST_SAVE: begin
                    state_d[i] = ST_ISO;
                    dly_d[i]   = '0;
                end
                ST_ISO: begin
                    if (dly_q[i] == ISO_LAST) begin
                        state_d[i] = ST_OFF;
                        dly_d[i]   = '0;
                    end else begin
                        dly_d[i] = dly_q[i] + 1'b1;
                    end
                end
                ST_OFF: begin
                    if (grant[i]) begin
                        state_d[i] = ST_UP;
                        dly_d[i]   = '0;
                    end
                end
                ST_UP: begin
                    if (dly_q[i] == RAMP_LAST) begin
                        state_d[i] = ST_RESTORE;
                        dly_d[i]   = '0;
                    end else begin
                        dly_d[i] = dly_q[i] + 1'b1;
                    end
                end
                ST_RESTORE: state_d[i] = ST_ON;
                default:    state_d[i] = ST_ON;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_DOM; i++) begin
            if (rst) begin
                state_q[i] <= ST_ON;
                dly_q[i]   <= '0;
            end else begin
                state_q[i] <= state_d[i];
                dly_q[i]   <= dly_d[i];
            end
        end
    end

    // Every control output is a pure decode of the registered state.
    always_comb begin
        pwr_sw_en   = '0;
        iso_en      = '0;
        ret_save    = '0;
        ret_restore = '0;
        dom_rst     = '0;
        pwr_ack     = '0;
        busy        = 1'b0;
        for (int i = 0; i < N_DOM; i++) begin
            case (state_q[i])
                ST_ON: begin
                    pwr_sw_en[i] = 1'b1;
                    pwr_ack[i]   = 1'b1;
                end
                ST_SAVE: begin
                    pwr_sw_en[i] = 1'b1;
                    ret_save[i]  = 1'b1;
                end
                ST_ISO: begin
                    pwr_sw_en[i] = 1'b1;
                    iso_en[i]    = 1'b1;
                end
                ST_OFF: begin
                    iso_en[i]  = 1'b1;
                    dom_rst[i] = 1'b1;
                end
                ST_UP: begin
                    pwr_sw_en[i] = 1'b1;
                    iso_en[i]    = 1'b1;
                    dom_rst[i]   = 1'b1;
                end
                ST_RESTORE: begin
                    pwr_sw_en[i]   = 1'b1;
                    iso_en[i]      = 1'b1;
                    ret_restore[i] = 1'b1;
                end
                default: begin
                    pwr_sw_en[i] = 1'b1;
                    pwr_ack[i]   = 1'b1;
                end
            endcase
            if (state_q[i] != ST_ON && state_q[i] != ST_OFF) busy = 1'b1;
        end
    end

`ifdef PWR_WAKE_CNT_EN
    localparam logic [CNT_W-1:0] WAKE_MAX = '1;
    logic [CNT_W-1:0] wake_q [N_DOM];

    // A grant is exactly the OFF->UP transition, so it doubles as the wake strobe.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_DOM; i++) begin
            if (rst) begin
                wake_q[i] <= '0;
            end else if (grant[i] && wake_q[i] != WAKE_MAX) begin
                wake_q[i] <= wake_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        wake_cnt = '0;
        for (int i = 0; i < N_DOM; i++) begin
            wake_cnt[i*CNT_W +: CNT_W] = wake_q[i];
        end
    end
`endif

endmodule
